// File: rtl/bp_sacc_io_initiator_pkg.sv
// Shared types for the streaming-accelerator I/O initiator.
// Holds the processor-config widths, the CCE memory message layout used on the
// io_cmd/io_resp link, the host request opcodes and the initiator FSM states.
package bp_sacc_io_initiator_pkg;

    localparam int paddr_width_p  = 40;
    localparam int dword_width_p  = 64;
    localparam int lce_id_width_p = 4;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'b0000,
        e_cce_mem_wr    = 4'b0001,
        e_cce_mem_uc_rd = 4'b0010,
        e_cce_mem_uc_wr = 4'b0011
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'b000,
        e_mem_size_2  = 3'b001,
        e_mem_size_4  = 3'b010,
        e_mem_size_8  = 3'b011,
        e_mem_size_16 = 3'b100,
        e_mem_size_32 = 3'b101,
        e_mem_size_64 = 3'b110
    } bp_mem_msg_size_e;

    typedef struct packed {
        logic [lce_id_width_p-1:0] lce_id;
    } bp_cce_mem_msg_payload_s;

    typedef struct packed {
        bp_cce_mem_cmd_type_e     msg_type;
        logic [paddr_width_p-1:0] addr;
        bp_mem_msg_size_e         size;
        bp_cce_mem_msg_payload_s  payload;
        logic [dword_width_p-1:0] data;
    } bp_cce_mem_msg_s;

    localparam int cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);

    typedef enum logic [1:0] {
        e_sacc_op_rd         = 2'b00,
        e_sacc_op_wr         = 2'b01,
        e_sacc_op_start_wait = 2'b10,
        e_sacc_op_illegal    = 2'b11
    } bp_sacc_op_e;

    typedef enum logic [2:0] {
        e_st_idle,
        e_st_send,
        e_st_wait,
        e_st_pgap,
        e_st_psend,
        e_st_pwait,
        e_st_reply
    } bp_sacc_state_e;

endpackage

// File: rtl/bp_sacc_io_initiator.sv
// Host-side initiator for the streaming-accelerator I/O link.
// Issues one uncached read/write toward an accelerator io-cce at a time, or runs
// start-and-wait: write the start CSR, then poll the status CSR (start address +
// status_offset_p) every poll_gap_p cycles until bit 0 is set.
// Ports:
//   clk_i, reset_n_i              clock, asynchronous active-low reset
//   lce_id_i                      stamped into the command payload
//   req_*                         host request (op, addr, data), valid/ready
//   rsp_*                         host reply (data, err), held until rsp_yumi_i
//   io_cmd_o/_v_o/_ready_i        command to accelerator, ready/valid
//   io_resp_i/_v_i/_yumi_o        response from accelerator, valid/yumi
module bp_sacc_io_initiator
    import bp_sacc_io_initiator_pkg::*;
#(
    parameter int                       timeout_p       = 1024,
    parameter int                       poll_gap_p      = 16,
    parameter int                       max_polls_p     = 64,
    parameter logic [paddr_width_p-1:0] status_offset_p = 'h8
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic [lce_id_width_p-1:0]  lce_id_i,
    input  logic [1:0]                 req_op_i,
    input  logic [paddr_width_p-1:0]   req_addr_i,
    input  logic [dword_width_p-1:0]   req_data_i,
    input  logic                       req_v_i,
    output logic                       req_ready_o,
    output logic [dword_width_p-1:0]   rsp_data_o,
    output logic                       rsp_err_o,
    output logic                       rsp_v_o,
    input  logic                       rsp_yumi_i,
    output bp_cce_mem_msg_s            io_cmd_o,
    output logic                       io_cmd_v_o,
    input  logic                       io_cmd_ready_i,
    input  bp_cce_mem_msg_s            io_resp_i,
    input  logic                       io_resp_v_i,
    output logic                       io_resp_yumi_o
);

    localparam int timer_w = $clog2(timeout_p + 1);
    localparam int gap_w   = $clog2(poll_gap_p + 1);
    localparam int poll_w  = $clog2(max_polls_p + 1);

    localparam logic [timer_w-1:0] timer_last = timer_w'(timeout_p - 1);
    localparam logic [timer_w-1:0] timer_max  = timer_w'(timeout_p);
    localparam logic [gap_w-1:0]   gap_last   = gap_w'(poll_gap_p - 1);
    localparam logic [poll_w-1:0]  poll_limit = poll_w'(max_polls_p);

    bp_sacc_state_e            state_r;
    bp_sacc_op_e               op_r;
    logic [paddr_width_p-1:0]  addr_r;
    bp_cce_mem_msg_s           cmd_r;
    logic                      cmd_v_r;
    logic                      req_ready_r;
    logic                      rsp_v_r;
    logic                      rsp_err_r;
    logic [dword_width_p-1:0]  rsp_data_r;
    logic [timer_w-1:0]        timer_r;
    logic [gap_w-1:0]          gap_r;
    logic [poll_w-1:0]         polls_r;

    logic                      resp_match;
    logic [paddr_width_p-1:0]  poll_addr;
    logic [poll_w-1:0]         polls_next;
    logic                      unused_resp_fields;

    // The response must echo the command just sent; cmd_r always holds it.
    assign resp_match = (io_resp_i.msg_type == cmd_r.msg_type) && (io_resp_i.addr == cmd_r.addr);
    assign poll_addr  = addr_r + status_offset_p;
    assign polls_next = polls_r + 1'b1;

    assign unused_resp_fields = &{1'b0, io_resp_i.size, io_resp_i.payload};

    // Every response is consumed on arrival; ones not expected in the current
    // state are simply dropped.
    assign io_resp_yumi_o = io_resp_v_i & reset_n_i;

    assign req_ready_o = req_ready_r;
    assign rsp_v_o     = rsp_v_r;
    assign rsp_err_o   = rsp_err_r;
    assign rsp_data_o  = rsp_data_r;
    assign io_cmd_o    = cmd_r;
    assign io_cmd_v_o  = cmd_v_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r     <= e_st_idle;
            op_r        <= e_sacc_op_rd;
            addr_r      <= '0;
            cmd_r       <= '0;
            cmd_v_r     <= 1'b0;
            req_ready_r <= 1'b1;
            rsp_v_r     <= 1'b0;
            rsp_err_r   <= 1'b0;
            rsp_data_r  <= '0;
            timer_r     <= '0;
            gap_r       <= '0;
            polls_r     <= '0;
        end else begin
            case (state_r)
                e_st_idle: begin
                    if (req_v_i && req_ready_r) begin
                        req_ready_r <= 1'b0;
                        op_r        <= bp_sacc_op_e'(req_op_i);
                        addr_r      <= req_addr_i;
                        if (bp_sacc_op_e'(req_op_i) == e_sacc_op_illegal) begin
                            rsp_v_r    <= 1'b1;
                            rsp_err_r  <= 1'b1;
                            rsp_data_r <= '0;
                            state_r    <= e_st_reply;
                        end else begin
                            cmd_r.msg_type       <= (bp_sacc_op_e'(req_op_i) == e_sacc_op_rd)
                                                    ? e_cce_mem_uc_rd : e_cce_mem_uc_wr;
                            cmd_r.addr           <= req_addr_i;
                            cmd_r.size           <= e_mem_size_8;
                            cmd_r.payload.lce_id <= lce_id_i;
                            cmd_r.data           <= (bp_sacc_op_e'(req_op_i) == e_sacc_op_rd)
                                                    ? '0 : req_data_i;
                            cmd_v_r              <= 1'b1;
                            state_r              <= e_st_send;
                        end
                    end
                end

                e_st_send, e_st_psend: begin
                    timer_r <= '0;
                    if (io_cmd_ready_i) begin
                        cmd_v_r <= 1'b0;
                        state_r <= (state_r == e_st_send) ? e_st_wait : e_st_pwait;
                    end
                end

                e_st_wait, e_st_pwait: begin
                    // A response arriving in the expiry cycle takes priority.
                    if (io_resp_v_i) begin
                        if (!resp_match) begin
                            rsp_v_r    <= 1'b1;
                            rsp_err_r  <= 1'b1;
                            rsp_data_r <= '0;
                            state_r    <= e_st_reply;
                        end else if (state_r == e_st_wait && op_r != e_sacc_op_start_wait) begin
                            rsp_v_r    <= 1'b1;
                            rsp_err_r  <= 1'b0;
                            rsp_data_r <= (op_r == e_sacc_op_rd) ? io_resp_i.data : '0;
                            state_r    <= e_st_reply;
                        end else if (state_r == e_st_wait) begin
                            gap_r   <= '0;
                            polls_r <= '0;
                            state_r <= e_st_pgap;
                        end else if (io_resp_i.data[0]) begin
                            rsp_v_r    <= 1'b1;
                            rsp_err_r  <= 1'b0;
                            rsp_data_r <= io_resp_i.data;
                            state_r    <= e_st_reply;
                        end else if (polls_next == poll_limit) begin
                            rsp_v_r    <= 1'b1;
                            rsp_err_r  <= 1'b1;
                            rsp_data_r <= '0;
                            state_r    <= e_st_reply;
                        end else begin
                            polls_r <= polls_next;
                            gap_r   <= '0;
                            state_r <= e_st_pgap;
                        end
                    end else if (timer_r == timer_last) begin
                        rsp_v_r    <= 1'b1;
                        rsp_err_r  <= 1'b1;
                        rsp_data_r <= '0;
                        state_r    <= e_st_reply;
                    end else if (timer_r != timer_max) begin
                        timer_r <= timer_r + 1'b1;
                    end
                end

                e_st_pgap: begin
                    if (gap_r == gap_last) begin
                        cmd_r.msg_type <= e_cce_mem_uc_rd;
                        cmd_r.addr     <= poll_addr;
                        cmd_r.data     <= '0;
                        cmd_v_r        <= 1'b1;
                        state_r        <= e_st_psend;
                    end else begin
                        gap_r <= gap_r + 1'b1;
                    end
                end

                e_st_reply: begin
                    if (rsp_yumi_i) begin
                        rsp_v_r     <= 1'b0;
                        req_ready_r <= 1'b1;
                        state_r     <= e_st_idle;
                    end
                end

                default: state_r <= e_st_idle;
            endcase
        end
    end

endmodule
